// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums N_TERMS unsigned 8-bit products per result on valid/ready ports
// Optional saturation and overflow flag when MAC_ACC_SAT_EN is defined.
module mac_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       p_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf
);

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic             w_xfer;
  logic             w_last;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_next;

  assign in_ready  = (r_state == S_ACC);
  assign sum_out   = r_sum;
  assign out_valid = r_valid;
  assign term_cnt  = r_cnt;

  assign w_xfer = in_ready && in_valid;
  assign w_last = (r_cnt == CNT_W'(N_TERMS - 1));
  // First term of a group starts from zero so nothing leaks across groups.
  assign w_base = (r_cnt == '0) ? '0 : r_acc;

`ifdef MAC_ACC_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           w_sticky;
  logic           r_sticky;
  logic           r_ovf;

  assign w_sum    = {1'b0, w_base} + (ACC_W+1)'(p_in);
  assign w_sticky = ((r_cnt != '0) && r_sticky) || w_sum[ACC_W];
  assign w_next   = w_sticky ? '1 : w_sum[ACC_W-1:0];
  assign ovf      = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_sticky <= 1'b0;
      if (r_state == S_DONE) r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_sticky <= w_last ? 1'b0 : w_sticky;
      if (w_last) r_ovf <= w_sticky;
    end
  end
`else
  assign w_next = w_base + ACC_W'(p_in);
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          // clr wins over a coincident transfer; that product is dropped.
          if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_sum   <= w_next;
              r_valid <= 1'b1;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_acc <= w_next;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clr) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_state <= S_ACC;
          end else if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed self-checking bench for mac_accumulator
// Three instances: defaults, ACC_W=9, N_TERMS=1.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default instance
  logic [7:0] a_p_in = '0;
  logic       a_in_valid = 1'b0, a_clr = 1'b0, a_out_ready = 1'b0;
  logic       a_in_ready, a_out_valid, a_ovf;
  logic [9:0] a_sum;
  logic [2:0] a_cnt;

  mac_accumulator #(.N_TERMS(4), .ACC_W(10), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .p_in(a_p_in), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .clr(a_clr), .sum_out(a_sum), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .term_cnt(a_cnt), .ovf(a_ovf)
  );

  // Narrow accumulator instance
  logic [7:0] b_p_in = '0;
  logic       b_in_valid = 1'b0, b_clr = 1'b0, b_out_ready = 1'b0;
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [8:0] b_sum;
  logic [2:0] b_cnt;

  mac_accumulator #(.N_TERMS(4), .ACC_W(9), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .p_in(b_p_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .clr(b_clr), .sum_out(b_sum), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .term_cnt(b_cnt), .ovf(b_ovf)
  );

  // Single-term instance
  logic [7:0] c_p_in = '0;
  logic       c_in_valid = 1'b0, c_clr = 1'b0, c_out_ready = 1'b0;
  logic       c_in_ready, c_out_valid, c_ovf;
  logic [9:0] c_sum;
  logic [2:0] c_cnt;

  mac_accumulator #(.N_TERMS(1), .ACC_W(10), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .p_in(c_p_in), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .clr(c_clr), .sum_out(c_sum), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .term_cnt(c_cnt), .ovf(c_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_xfer(input logic [7:0] v);
    a_p_in     = v;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_release();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_sum", 32'(a_sum), 32'd0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Four x 225 back-to-back
    a_p_in = 8'd225; a_in_valid = 1'b1;
    step(); check("bb_cnt1", 32'(a_cnt), 32'd1);
    step(); check("bb_cnt2", 32'(a_cnt), 32'd2);
    step(); check("bb_cnt3", 32'(a_cnt), 32'd3);
    check("bb_not_yet_valid", 32'(a_out_valid), 32'd0);
    step(); a_in_valid = 1'b0;
    check("bb_cnt0", 32'(a_cnt), 32'd0);
    check("bb_valid", 32'(a_out_valid), 32'd1);
    check("bb_sum900", 32'(a_sum), 32'd900);
    check("bb_ovf", 32'(a_ovf), 32'd0);
    check("bb_in_ready0", 32'(a_in_ready), 32'd0);
    a_release();
    check("bb_valid_drop", 32'(a_out_valid), 32'd0);
    check("bb_in_ready1", 32'(a_in_ready), 32'd1);

    // 3,5,7,9 with two-cycle gaps, then back-pressure
    a_xfer(8'd3); step(); step();
    a_xfer(8'd5); step(); step();
    a_xfer(8'd7); step(); step();
    check("gap_cnt3", 32'(a_cnt), 32'd3);
    a_xfer(8'd9);
    for (int i = 0; i < 5; i++) begin
      check("hold_sum24", 32'(a_sum), 32'd24);
      check("hold_valid", 32'(a_out_valid), 32'd1);
      check("hold_in_ready0", 32'(a_in_ready), 32'd0);
      step();
    end
    a_release();
    check("gap_valid_drop", 32'(a_out_valid), 32'd0);
    check("gap_in_ready1", 32'(a_in_ready), 32'd1);

    // clr mid-group, clr with simultaneous product, clr in DONE
    a_xfer(8'd100);
    a_xfer(8'd100);
    check("clr_pre_cnt2", 32'(a_cnt), 32'd2);
    a_clr = 1'b1; a_p_in = 8'd50; a_in_valid = 1'b1;
    check("clr_in_ready", 32'(a_in_ready), 32'd1);
    step();
    a_clr = 1'b0; a_in_valid = 1'b0;
    check("clr_cnt0", 32'(a_cnt), 32'd0);
    a_xfer(8'd10); a_xfer(8'd20); a_xfer(8'd30); a_xfer(8'd40);
    check("clr_sum100", 32'(a_sum), 32'd100);
    check("clr_valid", 32'(a_out_valid), 32'd1);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("clr_done_valid", 32'(a_out_valid), 32'd0);
    check("clr_done_sum", 32'(a_sum), 32'd0);
    check("clr_done_in_ready", 32'(a_in_ready), 32'd1);

    // Async reset mid-group
    a_xfer(8'd1); a_xfer(8'd2);
    check("arst_pre_cnt2", 32'(a_cnt), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_mid_cnt", 32'(a_cnt), 32'd0);
    check("arst_mid_valid", 32'(a_out_valid), 32'd0);
    step();
    rst = 1'b0;
    // Async reset in DONE
    a_xfer(8'd5); a_xfer(8'd5); a_xfer(8'd5); a_xfer(8'd5);
    check("arst_done_pre", 32'(a_sum), 32'd20);
    #2 rst = 1'b1;
    #1;
    check("arst_done_valid", 32'(a_out_valid), 32'd0);
    check("arst_done_sum", 32'(a_sum), 32'd0);
    check("arst_done_in_ready", 32'(a_in_ready), 32'd1);
    step();
    rst = 1'b0;
    a_xfer(8'd1); a_xfer(8'd2); a_xfer(8'd3); a_xfer(8'd4);
    check("arst_after_sum10", 32'(a_sum), 32'd10);
    check("arst_after_valid", 32'(a_out_valid), 32'd1);
    a_release();

    // ACC_W=9 overflow handling
    b_p_in = 8'd225; b_in_valid = 1'b1;
    step(); step(); step(); step();
    b_in_valid = 1'b0;
    check("ovf_valid", 32'(b_out_valid), 32'd1);
`ifdef MAC_ACC_SAT_EN
    check("ovf_sum_sat", 32'(b_sum), 32'd511);
    check("ovf_flag", 32'(b_ovf), 32'd1);
`else
    check("ovf_sum_wrap", 32'(b_sum), 32'd388);
    check("ovf_flag", 32'(b_ovf), 32'd0);
`endif
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    b_p_in = 8'd1; b_in_valid = 1'b1;
    step(); step(); step(); step();
    b_in_valid = 1'b0;
    check("ovf_next_sum4", 32'(b_sum), 32'd4);
    check("ovf_next_flag0", 32'(b_ovf), 32'd0);

    // N_TERMS=1
    c_p_in = 8'd255; c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    check("n1_sum255", 32'(c_sum), 32'd255);
    check("n1_valid", 32'(c_out_valid), 32'd1);
    check("n1_in_ready0", 32'(c_in_ready), 32'd0);
    check("n1_cnt0", 32'(c_cnt), 32'd0);
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
    check("n1_valid_drop", 32'(c_out_valid), 32'd0);
    c_p_in = 8'd17; c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    check("n1_sum17", 32'(c_sum), 32'd17);
    check("n1_valid2", 32'(c_out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
